// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Byte-to-serial UART transmit stage. Bytes arrive over a valid/ready
// handshake into a small FIFO and leave as 10-bit frames (start, d0..d7
// LSB-first, stop) on UART_tx, with a companion bit clock UART_clk that
// rises once per bit at mid-bit and stays low while the line is idle.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   rst       asynchronous active-high reset
//   tx_data   byte to transmit
//   tx_valid  tx_data is valid this cycle
//   tx_ready  FIFO can accept a byte (push = tx_valid && tx_ready)
//   busy      a frame is in progress or the FIFO holds bytes
//   UART_tx   serial data, idle high (registered)
//   UART_clk  bit clock, low when idle (registered)
module uart_tx_serializer #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       UART_tx,
  output logic       UART_clk
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = $clog2(2 * CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  // Serializer state
  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [2:0]    bitcnt_q;
  logic [2:0]    bitcnt_d;
  logic [7:0]    sh_q;
  logic [7:0]    sh_d;
  logic          tx_q;
  logic          tx_d;
  logic          uclk_q;
  logic          uclk_d;
  logic          bit_end_s;

  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == {CW{1'b0}});
  assign push_s    = tx_valid && !full_s;
  assign bit_end_s = (div_q == DIV_LAST);

  assign tx_ready  = !full_s;
  assign busy      = (state_q != S_IDLE) || !empty_s;
  assign UART_tx   = tx_q;
  assign UART_clk  = uclk_q;

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset discards any buffered bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO data storage (contents are don't-care once pointers reset)
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= tx_data;
  end

  // Frame FSM next-state; a byte is popped on leaving IDLE or at the end of
  // STOP, so consecutive frames run with no idle gap
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          sh_d     = mem_q[rd_ptr_q];
          bitcnt_d = 3'd0;
          div_d    = {DW{1'b0}};
          state_d  = S_START;
        end else begin
          div_d    = {DW{1'b0}};
        end
      end
      S_START: begin
        if (bit_end_s) begin
          div_d    = {DW{1'b0}};
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end else begin
          div_d    = div_q + DW'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          div_d = {DW{1'b0}};
          if (bitcnt_q == 3'd7) begin
            state_d  = S_STOP;
          end else begin
            sh_d     = sh_q >> 1;
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          div_d = {DW{1'b0}};
          if (!empty_s) begin
            pop_s    = 1'b1;
            sh_d     = mem_q[rd_ptr_q];
            bitcnt_d = 3'd0;
            state_d  = S_START;
          end else begin
            state_d  = S_IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = {DW{1'b0}};
      end
    endcase
  end

  // Line outputs derived from the current state; registered so both pins
  // move together one clock after the state they describe
  always_comb begin
    tx_d   = 1'b1;
    uclk_d = 1'b0;
    case (state_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_q[0];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    if (state_q != S_IDLE) begin
      uclk_d = (div_q >= DIV_HALF);
    end else begin
      uclk_d = 1'b0;
    end
  end

  // Serializer state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= {DW{1'b0}};
      bitcnt_q <= 3'd0;
      sh_q     <= 8'h00;
      tx_q     <= 1'b1;
      uclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      uclk_q   <= uclk_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] da = 8'h00, db = 8'h00;
  logic       va = 1'b0, vb = 1'b0;
  logic       ready_a, busy_a, txa, ucka;
  logic       ready_b, busy_b, txb, uckb;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state: accepted bytes in order, decoded frames, edge times
  logic [7:0] exp_a[$], exp_b[$];
  logic [9:0] frames_a[$], frames_b[$];
  int         edges_a[$], edges_b[$];
  logic [9:0] sh_a = 10'h0, sh_b = 10'h0;
  int         pos_a = 0, pos_b = 0;
  logic       prev_a = 1'b0, prev_b = 1'b0;

  uart_tx_serializer #(.CLK_DIV(DIV_A), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(da), .tx_valid(va), .tx_ready(ready_a),
    .busy(busy_a), .UART_tx(txa), .UART_clk(ucka));

  uart_tx_serializer #(.CLK_DIV(DIV_B), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_data(db), .tx_valid(vb), .tx_ready(ready_b),
    .busy(busy_b), .UART_tx(txb), .UART_clk(uckb));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver model for A: sample UART_tx at each UART_clk rising edge
  always @(negedge clk) begin
    if (rst) begin
      pos_a  <= 0;
      prev_a <= 1'b0;
    end else begin
      prev_a <= ucka;
      if (ucka && !prev_a) begin
        edges_a.push_back(cyc);
        if (pos_a == 9) begin
          frames_a.push_back({txa, sh_a[9:1]});
          pos_a <= 0;
        end else begin
          pos_a <= pos_a + 1;
        end
        sh_a <= {txa, sh_a[9:1]};
      end
    end
  end

  // UART receiver model for B
  always @(negedge clk) begin
    if (rst) begin
      pos_b  <= 0;
      prev_b <= 1'b0;
    end else begin
      prev_b <= uckb;
      if (uckb && !prev_b) begin
        edges_b.push_back(cyc);
        if (pos_b == 9) begin
          frames_b.push_back({txb, sh_b[9:1]});
          pos_b <= 0;
        end else begin
          pos_b <= pos_b + 1;
        end
        sh_b <= {txb, sh_b[9:1]};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock cycle of stimulus; starts and ends at posedge+1
  task automatic drive(input int sel, input logic v, input logic [7:0] d, output logic acc);
    if (sel == 0) begin va = v; da = d; end
    else begin vb = v; db = d; end
    @(negedge clk);
    acc = v && ((sel == 0) ? ready_a : ready_b);
    @(posedge clk); #1;
    if (acc) begin
      if (sel == 0) exp_a.push_back(d);
      else exp_b.push_back(d);
    end
    if (sel == 0) va = 1'b0;
    else vb = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input int budget);
    int n = 0;
    while (((sel == 0) ? busy_a : busy_b) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", (sel == 0) ? busy_a : busy_b, 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int sel, input string tag);
    logic [9:0] f;
    logic [7:0] e;
    while (((sel == 0) ? frames_a.size() : frames_b.size()) > 0) begin
      if (sel == 0) f = frames_a.pop_front();
      else f = frames_b.pop_front();
      if (sel == 0) e = (exp_a.size() > 0) ? exp_a.pop_front() : ~f[8:1];
      else e = (exp_b.size() > 0) ? exp_b.pop_front() : ~f[8:1];
      check({tag, "_start"}, f[0], 0);
      check({tag, "_stop"}, f[9], 1);
      check({tag, "_data"}, f[8:1], e);
    end
    check({tag, "_left"}, (sel == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  initial begin
    logic acc;
    int   lat, fall_cyc, snap, bad, nacc, nlow, steps, tries;
    logic [7:0] rb;
    logic [7:0] burst [4];

    burst[0] = 8'h48; burst[1] = 8'h69; burst[2] = 8'h21; burst[3] = 8'h0A;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_a", txa, 1);   check("rst_clk_a", ucka, 0);
    check("rst_rdy_a", ready_a, 1); check("rst_busy_a", busy_a, 0);
    check("rst_tx_b", txb, 1);   check("rst_clk_b", uckb, 0);
    check("rst_rdy_b", ready_b, 1); check("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // single byte: latency, bit pattern, edge timing, frame length
    edges_a.delete();
    drive(0, 1'b1, 8'h48, acc);
    check("t2_acc", acc, 1);
    lat = 0;
    while (txa && lat < 10) begin @(posedge clk); #1; lat++; end
    check("t2_latency", lat, 2);
    fall_cyc = cyc;
    repeat (79) begin @(posedge clk); #1; end
    check("t2_clk_last", ucka, 1);
    check("t2_busy_end", busy_a, 0);
    @(posedge clk); #1;
    check("t2_clk_end", ucka, 0);
    check("t2_tx_end", txa, 1);
    check("t2_edges", edges_a.size(), 10);
    if (edges_a.size() == 10) begin
      check("t2_first_edge", edges_a[0] - fall_cyc, DIV_A);
      check("t2_last_edge", edges_a[9] - fall_cyc, 19 * DIV_A);
    end
    if (frames_a.size() > 0) check("t2_frame", frames_a[0], {1'b1, 8'h48, 1'b0});
    drain(0, "t2");

    // back-to-back burst
    edges_a.delete();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, burst[i], acc);
      check("t3_acc", acc, 1);
    end
    wait_idle(0, 1000);
    check("t3_edges", edges_a.size(), 40);
    if (edges_a.size() == 40) check("t3_no_gap", edges_a[39] - edges_a[0], 39 * 2 * DIV_A);
    drain(0, "t3");

    // full FIFO backpressure with valid held high
    nacc = 0; nlow = 0; steps = 0;
    while (nacc < 8 && steps < 2000) begin
      drive(0, 1'b1, 8'(nacc), acc);
      if (acc) nacc++;
      else nlow++;
      steps++;
      if (steps == 5) begin
        check("t4_acc5", nacc, 5);
        check("t4_ready_low", ready_a, 0);
      end
    end
    check("t4_accepted", nacc, 8);
    check("t4_saw_backpressure", (nlow > 0) ? 1 : 0, 1);
    wait_idle(0, 2000);
    drain(0, "t4");

    // idle line stays quiet
    snap = edges_a.size();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (txa !== 1'b1 || ucka !== 1'b0) bad++;
    end
    check("t5_quiet", bad, 0);
    check("t5_edges", edges_a.size(), snap);

    // randomized bytes with random gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 20)) drive(0, 1'b0, 8'h00, acc);
      rb = 8'($urandom());
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 500) begin
        drive(0, 1'b1, rb, acc);
        tries++;
      end
      check("rnd_acc", acc, 1);
    end
    wait_idle(0, 3000);
    drain(0, "rnd");

    // divider of one on the second instance
    edges_b.delete();
    drive(1, 1'b1, 8'hFF, acc);
    check("t6_acc0", acc, 1);
    drive(1, 1'b1, 8'h00, acc);
    check("t6_acc1", acc, 1);
    wait_idle(1, 500);
    check("t6_edges", edges_b.size(), 20);
    if (edges_b.size() == 20) check("t6_period", edges_b[19] - edges_b[0], 19 * 2 * DIV_B);
    drain(1, "t6");

    // reset during DATA bit 3
    drive(0, 1'b1, 8'h41, acc);
    lat = 0;
    while (txa && lat < 10) begin @(posedge clk); #1; lat++; end
    repeat (2 * DIV_A * 4 + 2) begin @(posedge clk); #1; end
    check("t1_busy_pre", busy_a, 1);
    rst = 1'b1;
    #1;
    check("t1_tx", txa, 1);
    check("t1_clk", ucka, 0);
    check("t1_ready", ready_a, 1);
    check("t1_busy", busy_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    frames_a.delete();
    snap = edges_a.size();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (txa !== 1'b1 || ucka !== 1'b0) bad++;
    end
    check("t1_quiet", bad, 0);
    check("t1_edges", edges_a.size(), snap);
    check("t1_frames", frames_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
